fibo_param: RTL and testbench
=============================

// Module: fibo_param
// PURPOSE
//  Parametrised iterative Fibonacci engine: F(i) computed with one add per clock,
//  F(0)=0, F(1)=1. Result and overflow flag held in output registers until next
//  completion. Adds abort and saturating overflow detection.
//  Used as a start/done-tick coprocessor under a controlling FSM or test harness.
// PARAMETERS
//  DW   32  result width in bits (f, internal t0/t1)
//  NW   6   index width in bits (i, internal down-counter)
// PORTS
//  clk        in   1    system clock, rising-edge
//  rst        in   1    asynchronous, active-high reset
//  start      in   1    request; sampled only in IDLE
//  abort      in   1    cancel computation in progress
//  i          in   NW   index n for F(n); captured on accepted start
//  ready      out  1    1 in IDLE (start will be accepted)
//  done_tick  out  1    one-cycle pulse in DONE
//  f          out  DW   last completed result (registered)
//  ovf        out  1    last result overflowed DW bits (registered)
// BEHAVIOUR
//  Reset: state=IDLE, t0=t1=0, n=0, f=0, ovf=0; ready=1, done_tick=0.
//  Reset mid-operation aborts immediately; no done_tick.
//  States: IDLE -> OP -> DONE -> IDLE.
//  IDLE: ready=1. start&!abort: t0<=0, t1<=1, n<=i, ovf_int<=0, -> OP.
//   start&abort same cycle: abort wins, stay IDLE.
//  OP (ready=0), priority order:
//   1 abort: -> IDLE; f, ovf keep previous values; no done_tick.
//   2 n==0: result 0 -> DONE.
//   3 n==1: result t1 -> DONE.
//   4 else: sum = {1'b0,t1}+{1'b0,t0} (DW+1 bits).
//     sum[DW]=1: result all-ones, ovf_int=1 -> DONE (early exit).
//     else t1<=sum[DW-1:0], t0<=t1, n<=n-1, stay OP.
//  DONE: done_tick=1 for exactly one cycle; -> IDLE. start ignored.
//  f/ovf registers load on the OP->DONE edge, so valid in same cycle as
//   done_tick; hold until next completion.
//  Latency: with start sampled at edge E0, done_tick high in cycle after edge
//   E0+max(i,1) (no overflow); ready returns the following edge.
//  Overflow exit: DONE entered one edge early (on the overflowing add).
//  start while !ready: ignored, not queued. i changes after acceptance: no effect.
//  Back-to-back: start asserted in cycle after done_tick is accepted.
//  i wider than any representable F: handled by overflow path, no wrap.
// TESTING
//  DW=20,NW=5: i=0 -> done_tick 1 edge after accept, f=0, ovf=0.
//  DW=20: i=1 -> f=1 after 1 edge; i=10 -> f=55 after 10 edges; ready=0 between.
//  DW=20: i=30 -> f=832040, ovf=0; i=31 -> f=20'hFFFFF, ovf=1, done_tick after 30 edges.
//  DW=32,NW=6: i=47 -> f=2971215073, ovf=0; i=48 -> f=32'hFFFFFFFF, ovf=1.
//  i=20 then abort after 5 cycles -> IDLE next edge, no done_tick, f/ovf keep
//   prior values; start+abort together in IDLE -> stays IDLE.
//  rst pulse mid-OP (i=25) -> f=0, ovf=0, ready=1 immediately; start during OP
//   or DONE ignored; back-to-back i=5 then i=6 -> f=5 then f=8.

Source files
------------

// File: rtl/fibo_param_if.sv
// +--------------------------------------------------------------------+
// | fibo_param_if                                                      |
// | Start/done handshake and result bus of the Fibonacci engine.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface fibo_param_if #(
  parameter int DW = 32,
  parameter int NW = 6
);
  logic          start;
  logic          abort;
  logic [NW-1:0] i;
  logic          ready;
  logic          done_tick;
  logic [DW-1:0] f;
  logic          ovf;

  // Controller side: issues requests, observes status and result
  modport master (
    output start, abort, i,
    input  ready, done_tick, f, ovf
  );

  // Engine side
  modport slave (
    input  start, abort, i,
    output ready, done_tick, f, ovf
  );
endinterface

`default_nettype wire

// File: rtl/fibo_param.sv
// +--------------------------------------------------------------------+
// | fibo_param                                                         |
// | Iterative Fibonacci engine, one add per clock, with abort and      |
// | saturating overflow detection. Result/flag held until next done.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fibo_param #(
  parameter int DW = 32,
  parameter int NW = 6
) (
  input  wire logic   clk,
  input  wire logic   rst,
  fibo_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DW-1:0] ONE_DW = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] ONE_NW = {{(NW-1){1'b0}}, 1'b1};

  state_t        state, state_next;
  logic [DW-1:0] t0, t0_next;
  logic [DW-1:0] t1, t1_next;
  logic [NW-1:0] n, n_next;
  logic [DW-1:0] f_reg, f_next;
  logic          ovf_reg, ovf_next;
  logic [DW:0]   sum;

  // One extra bit on the add exposes overflow of the next Fibonacci term
  assign sum = {1'b0, t1} + {1'b0, t0};

  // State and datapath registers; reset also cancels any computation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      t0      <= '0;
      t1      <= '0;
      n       <= '0;
      f_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      state   <= state_next;
      t0      <= t0_next;
      t1      <= t1_next;
      n       <= n_next;
      f_reg   <= f_next;
      ovf_reg <= ovf_next;
    end
  end

  // Next-state and datapath update; f/ovf only change on the OP->DONE edge
  always_comb begin
    state_next = state;
    t0_next    = t0;
    t1_next    = t1;
    n_next     = n;
    f_next     = f_reg;
    ovf_next   = ovf_reg;
    case (state)
      IDLE: begin
        // abort in the same cycle as start suppresses the request
        if (bus.start && !bus.abort) begin
          t0_next    = '0;
          t1_next    = ONE_DW;
          n_next     = bus.i;
          state_next = OP;
        end
      end
      OP: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (n == '0) begin
          f_next     = '0;
          ovf_next   = 1'b0;
          state_next = DONE;
        end else if (n == ONE_NW) begin
          f_next     = t1;
          ovf_next   = 1'b0;
          state_next = DONE;
        end else if (sum[DW]) begin
          // next term does not fit: saturate and finish early
          f_next     = '1;
          ovf_next   = 1'b1;
          state_next = DONE;
        end else begin
          t1_next = sum[DW-1:0];
          t0_next = t1;
          n_next  = n - ONE_NW;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done_tick = (state == DONE);
  assign bus.f         = f_reg;
  assign bus.ovf       = ovf_reg;

endmodule

`default_nettype wire

// File: tb/tb_fibo_param.sv
// +--------------------------------------------------------------------+
// | tb_fibo_param                                                      |
// | Scoreboard bench for fibo_param at DW=20/NW=5 and DW=32/NW=6.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fibo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] f;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  fibo_param_if #(.DW(20), .NW(5)) ia ();
  fibo_param_if #(.DW(32), .NW(6)) ib ();

  fibo_param #(.DW(20), .NW(5)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  fibo_param #(.DW(32), .NW(6)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  // Free-running cycle count used to time-stamp expected done_tick cycles
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation for each done_tick of each DUT
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ia.done_tick) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = qa.pop_front();
          check("a_f", {12'd0, ia.f}, e.f);
          check("a_ovf", 32'(ia.ovf), 32'(e.ovf));
          check("a_latency", 32'(cyc), 32'(e.at));
        end
      end
      if (ib.done_tick) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = qb.pop_front();
          check("b_f", ib.f, e.f);
          check("b_ovf", 32'(ib.ovf), 32'(e.ovf));
          check("b_latency", 32'(cyc), 32'(e.at));
        end
      end
    end
  endtask

  task automatic wait_ready_a();
    int k = 0;
    while (!ia.ready && k < 100) begin @(negedge clk); k++; end
    if (!ia.ready) begin
      checks++; errors++;
      $display("FAIL a_ready_timeout actual=0 expected=1");
    end
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (qa.size() != 0 && k < 400) begin @(negedge clk); k++; end
    if (qa.size() != 0) begin
      checks++; errors++;
      $display("FAIL a_done_timeout actual=pending expected=done");
      qa.delete();
    end
  endtask

  task automatic wait_idle_b();
    int k = 0;
    while (qb.size() != 0 && k < 400) begin @(negedge clk); k++; end
    if (qb.size() != 0) begin
      checks++; errors++;
      $display("FAIL b_done_timeout actual=pending expected=done");
      qb.delete();
    end
  endtask

  // One request on DUT A: lat = edges from accept to the DONE edge
  task automatic run_a(input logic [4:0] idx, input logic [31:0] ef, input logic eo, input int lat);
    wait_ready_a();
    ia.i = idx;
    ia.start = 1'b1;
    qa.push_back('{f: ef, ovf: eo, at: cyc + 1 + lat});
    @(negedge clk);
    ia.start = 1'b0;
    check("a_ready_busy", 32'(ia.ready), 32'd0);
    wait_idle_a();
  endtask

  task automatic run_b(input logic [5:0] idx, input logic [31:0] ef, input logic eo, input int lat);
    int k = 0;
    while (!ib.ready && k < 100) begin @(negedge clk); k++; end
    ib.i = idx;
    ib.start = 1'b1;
    qb.push_back('{f: ef, ovf: eo, at: cyc + 1 + lat});
    @(negedge clk);
    ib.start = 1'b0;
    check("b_ready_busy", 32'(ib.ready), 32'd0);
    wait_idle_b();
  endtask

  initial begin
    int k0;
    ia.start = 1'b0; ia.abort = 1'b0; ia.i = '0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.i = '0;
    fork
      monitor_loop();
    join_none

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ia.ready), 32'd1);
    check("rst_done", 32'(ia.done_tick), 32'd0);
    check("rst_f", {12'd0, ia.f}, 32'd0);
    check("rst_ovf", 32'(ia.ovf), 32'd0);
    check("rst_b_f", ib.f, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed results on the 20-bit engine
    run_a(5'd0,  32'd0,      1'b0, 1);
    run_a(5'd1,  32'd1,      1'b0, 1);
    run_a(5'd10, 32'd55,     1'b0, 10);
    run_a(5'd30, 32'd832040, 1'b0, 30);
    run_a(5'd31, 32'hFFFFF,  1'b1, 30);

    // Abort during OP: back to IDLE, previous f/ovf retained, no done_tick
    wait_ready_a();
    ia.i = 5'd20; ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", 32'(ia.ready), 32'd0);
    ia.abort = 1'b1;
    @(negedge clk);
    ia.abort = 1'b0;
    check("abort_ready", 32'(ia.ready), 32'd1);
    check("abort_f_hold", {12'd0, ia.f}, 32'hFFFFF);
    check("abort_ovf_hold", 32'(ia.ovf), 32'd1);
    repeat (25) @(negedge clk);

    // start and abort together in IDLE: request dropped
    ia.i = 5'd3; ia.start = 1'b1; ia.abort = 1'b1;
    @(negedge clk);
    ia.start = 1'b0; ia.abort = 1'b0;
    check("start_abort_ready", 32'(ia.ready), 32'd1);
    repeat (10) @(negedge clk);

    // start held high: i change after accept and start in OP/DONE ignored,
    // then the next request is accepted in the IDLE cycle after done_tick
    k0 = cyc;
    ia.i = 5'd5; ia.start = 1'b1;
    qa.push_back('{f: 32'd5, ovf: 1'b0, at: k0 + 6});
    qa.push_back('{f: 32'd8, ovf: 1'b0, at: k0 + 14});
    @(negedge clk);
    ia.i = 5'd6;
    while (cyc < k0 + 8) @(negedge clk);
    ia.start = 1'b0;
    wait_idle_a();

    // Asynchronous reset mid-OP clears outputs immediately
    run_a(5'd31, 32'hFFFFF, 1'b1, 30);
    wait_ready_a();
    ia.i = 5'd25; ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_f", {12'd0, ia.f}, 32'd0);
    check("midrst_ovf", 32'(ia.ovf), 32'd0);
    check("midrst_ready", 32'(ia.ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_a(5'd1, 32'd1, 1'b0, 1);

    // 32-bit engine: largest representable term and first overflow
    run_b(6'd47, 32'd2971215073, 1'b0, 47);
    run_b(6'd48, 32'hFFFFFFFF,   1'b1, 47);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
